// File: rtl/duty_ramp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : duty_ramp                                                   |
// | Function : PWM duty-threshold source. Fixed duties or a breathing      |
// |            triangle ramp, reloaded on PWM period boundaries.           |
// | Options  : DUTY_RAMP_GAMMA_EN - gamma-corrects the breathing level.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module duty_ramp #(
    parameter int STEP         = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_STEPS   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       enable,
    input  logic       period_end,
    output logic [7:0] seuil,
    output logic       seuil_load,
    output logic [2:0] ramp_state
);

    localparam int PW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PW-1:0] c_PER_LAST  = PW'(STEP_PERIODS - 1);
    localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [8:0]    c_STEP      = 9'(STEP);

    localparam logic [2:0] c_STATIC  = 3'd0;
    localparam logic [2:0] c_UP      = 3'd1;
    localparam logic [2:0] c_HOLD_HI = 3'd2;
    localparam logic [2:0] c_DOWN    = 3'd3;
    localparam logic [2:0] c_HOLD_LO = 3'd4;

    logic [2:0]    r_state;
    logic [7:0]    r_level;
    logic [PW-1:0] r_per_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic [7:0]    r_seuil;
    logic          r_seuil_load;

    logic [8:0] w_up_sum;
    logic [8:0] w_dn_diff;
    logic [7:0] w_up_level;
    logic [7:0] w_dn_level;
    logic [7:0] w_ramp_level;
    logic [7:0] w_target;
    logic       w_step;

    // 9-bit arithmetic: carry means overflow past 255, borrow means below 0
    assign w_up_sum   = {1'b0, r_level} + c_STEP;
    assign w_dn_diff  = {1'b0, r_level} - c_STEP;
    assign w_up_level = w_up_sum[8]  ? 8'hFF : w_up_sum[7:0];
    assign w_dn_level = w_dn_diff[8] ? 8'h00 : w_dn_diff[7:0];

    assign w_step = (r_state != c_STATIC) && enable && period_end &&
                    (r_per_cnt == c_PER_LAST);

`ifdef DUTY_RAMP_GAMMA_EN
    logic [7:0] r_gamma;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gamma <= 8'h00;
        end else if (r_level == 8'hFF) begin
            r_gamma <= 8'hFF;
        end else begin
            r_gamma <= 8'(({8'd0, r_level} * {8'd0, r_level}) >> 8);
        end
    end

    assign w_ramp_level = r_gamma;
`else
    assign w_ramp_level = r_level;
`endif

    always_comb begin
        w_target = w_ramp_level;
        case (mode)
            2'd0:    w_target = 8'd63;
            2'd1:    w_target = 8'd127;
            2'd2:    w_target = 8'd191;
            default: w_target = w_ramp_level;
        endcase
    end

    // Threshold reload; the target uses the pre-step level of this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seuil      <= 8'h00;
            r_seuil_load <= 1'b0;
        end else begin
            r_seuil_load <= period_end;
            if (period_end) begin
                r_seuil <= w_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_STATIC;
            r_level    <= 8'h00;
            r_per_cnt  <= '0;
            r_hold_cnt <= '0;
        end else if (mode != 2'd3) begin
            r_state <= c_STATIC;
            r_level <= 8'h00;
        end else if (r_state == c_STATIC) begin
            r_state    <= c_UP;
            r_level    <= 8'h00;
            r_per_cnt  <= '0;
            r_hold_cnt <= '0;
        end else if (enable && period_end) begin
            if (!w_step) begin
                r_per_cnt <= r_per_cnt + 1'b1;
            end else begin
                r_per_cnt <= '0;
                case (r_state)
                    c_UP: begin
                        r_level <= w_up_level;
                        if (w_up_level == 8'hFF) begin
                            r_state    <= c_HOLD_HI;
                            r_hold_cnt <= '0;
                        end
                    end
                    c_HOLD_HI: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state <= c_DOWN;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    c_DOWN: begin
                        r_level <= w_dn_level;
                        if (w_dn_level == 8'h00) begin
                            r_state    <= c_HOLD_LO;
                            r_hold_cnt <= '0;
                        end
                    end
                    c_HOLD_LO: begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state <= c_UP;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    default: r_state <= c_STATIC;
                endcase
            end
        end
    end

    assign seuil      = r_seuil;
    assign seuil_load = r_seuil_load;
    assign ramp_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_duty_ramp.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_duty_ramp                                                |
// | Function : Directed self-checking bench for duty_ramp.                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_duty_ramp;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode;
    logic       enable;
    logic       period_end;
    logic [7:0] seuil;
    logic       seuil_load;
    logic [2:0] ramp_state;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] c_STATIC  = 3'd0;
    localparam logic [2:0] c_UP      = 3'd1;
    localparam logic [2:0] c_HOLD_HI = 3'd2;
    localparam logic [2:0] c_DOWN    = 3'd3;
    localparam logic [2:0] c_HOLD_LO = 3'd4;

    duty_ramp #(
        .STEP         (64),
        .STEP_PERIODS (1),
        .HOLD_STEPS   (2)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .enable     (enable),
        .period_end (period_end),
        .seuil      (seuil),
        .seuil_load (seuil_load),
        .ramp_state (ramp_state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected mode-3 threshold for a given ramp level
    function automatic int ramp_exp(input int v);
`ifdef DUTY_RAMP_GAMMA_EN
        return (v == 255) ? 255 : ((v * v) >> 8);
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap);
        repeat (gap) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    int lvl_tbl[14] = '{0, 64, 128, 192, 255, 255, 255, 191, 127, 63, 0, 0, 0, 64};
    logic [2:0] st_tbl[14] = '{c_UP, c_UP, c_UP, c_HOLD_HI, c_HOLD_HI, c_DOWN, c_DOWN,
                               c_DOWN, c_DOWN, c_HOLD_LO, c_HOLD_LO, c_UP, c_UP, c_UP};

    initial begin
        reset_n    = 1'b0;
        mode       = 2'd1;
        enable     = 1'b1;
        period_end = 1'b0;

        // Reset and a fixed duty
        repeat (3) tick();
        chk("rst_seuil", 32'(seuil), 32'd0);
        chk("rst_load", 32'(seuil_load), 32'd0);
        chk("rst_state", 32'(ramp_state), 32'(c_STATIC));
        reset_n = 1'b1;
        repeat (4) tick();
        chk("m1_pre_seuil", 32'(seuil), 32'd0);
        pulse(0);
        chk("m1_seuil", 32'(seuil), 32'd127);
        chk("m1_load", 32'(seuil_load), 32'd1);
        tick();
        chk("m1_load_end", 32'(seuil_load), 32'd0);
        chk("m1_hold", 32'(seuil), 32'd127);

        // Breathing ramp, one full triangle
        mode = 2'd3;
        tick();
        chk("br_enter", 32'(ramp_state), 32'(c_UP));
        for (int i = 0; i < 14; i++) begin
            pulse(255);
            chk($sformatf("br_seuil%0d", i), 32'(seuil), 32'(ramp_exp(lvl_tbl[i])));
            chk($sformatf("br_load%0d", i), 32'(seuil_load), 32'd1);
            chk($sformatf("br_state%0d", i), 32'(ramp_state), 32'(st_tbl[i]));
        end

        // Freeze with enable low at level 128
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(20);
            chk($sformatf("frz_seuil%0d", i), 32'(seuil), 32'(ramp_exp(128)));
            chk($sformatf("frz_load%0d", i), 32'(seuil_load), 32'd1);
        end
        chk("frz_state", 32'(ramp_state), 32'(c_UP));
        enable = 1'b1;
        pulse(20);
        chk("res_seuil0", 32'(seuil), 32'(ramp_exp(128)));
        pulse(20);
        chk("res_seuil1", 32'(seuil), 32'(ramp_exp(192)));
        chk("res_state", 32'(ramp_state), 32'(c_HOLD_HI));

        // Mode change between boundaries
        repeat (10) tick();
        mode = 2'd2;
        tick();
        chk("mc_state", 32'(ramp_state), 32'(c_STATIC));
        chk("mc_seuil_kept", 32'(seuil), 32'(ramp_exp(192)));
        chk("mc_load_idle", 32'(seuil_load), 32'd0);
        pulse(15);
        chk("mc_seuil", 32'(seuil), 32'd191);
        chk("mc_load", 32'(seuil_load), 32'd1);
        mode = 2'd3;
        tick();
        chk("mc_restart", 32'(ramp_state), 32'(c_UP));
        pulse(20);
        chk("mc_lvl0", 32'(seuil), 32'(ramp_exp(0)));
        pulse(20);
        chk("mc_lvl64", 32'(seuil), 32'(ramp_exp(64)));

        // Walk to DOWN, then reset asynchronously
        pulse(20);
        pulse(20);
        pulse(20);
        pulse(20);
        pulse(20);
        chk("pre_rst_seuil", 32'(seuil), 32'(ramp_exp(255)));
        chk("pre_rst_state", 32'(ramp_state), 32'(c_DOWN));
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_seuil", 32'(seuil), 32'd0);
        chk("arst_state", 32'(ramp_state), 32'(c_STATIC));
        chk("arst_load", 32'(seuil_load), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("post_state", 32'(ramp_state), 32'(c_UP));
        repeat (5) tick();
        chk("post_seuil", 32'(seuil), 32'd0);
        pulse(20);
        chk("post_lvl0", 32'(seuil), 32'(ramp_exp(0)));
        pulse(20);
        chk("post_lvl64", 32'(seuil), 32'(ramp_exp(64)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
